// File: rtl/result_assembler.sv
// result_assembler: collects low/mid/high result slices into full words,
// buffers them in a small FIFO and frames the stream with busy/frame_done.
module result_assembler #(
    parameter int PART_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ELEMS      = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  part_valid,
    input  logic [1:0]            part_sel,
    input  logic [PART_W-1:0]     part_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*PART_W-1:0]   out_data,
    output logic [3:0]            elem_idx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  seq_err,
    output logic                  ovf_err
);
    // state   | meaning
    // IDLE    | waiting for frame_start, parts ignored
    // COLLECT | assembling low/mid/high triplets into words
    // DRAIN   | all elements seen, waiting for the FIFO to empty

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int WORD_W = 3 * PART_W;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [1:0]          expected;
    logic [PART_W-1:0]   low_q, mid_q;
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;

    logic start_frame, part_take, in_order, word_done;
    logic pop, full, push, drop, last_elem;

    assign start_frame = (state == IDLE) && frame_start;
    assign part_take   = (state == COLLECT) && part_valid;
    assign in_order    = part_take && (part_sel == expected);
    assign word_done   = in_order && (expected == 2'd2);
    assign out_valid   = (count != '0);
    assign out_data    = mem[rd_ptr];
    assign pop         = out_valid && out_ready;
    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    // a full FIFO can still take the word when the head leaves on the same edge
    assign push        = word_done && (!full || pop);
    assign drop        = word_done && full && !pop;
    assign last_elem   = (elem_idx == 4'(ELEMS - 1));

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state decode and Moore outputs
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_nxt = COLLECT;
            end
            COLLECT: begin
                busy = 1'b1;
                if (word_done && last_elem) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (count == '0) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // slice collection, element count and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            expected <= 2'd0;
            low_q    <= '0;
            mid_q    <= '0;
            elem_idx <= 4'd0;
            seq_err  <= 1'b0;
            ovf_err  <= 1'b0;
        end else if (start_frame) begin
            expected <= 2'd0;
            elem_idx <= 4'd0;
            seq_err  <= 1'b0;
            ovf_err  <= 1'b0;
        end else if (part_take) begin
            if (in_order) begin
                case (expected)
                    2'd0: begin
                        low_q    <= part_data;
                        expected <= 2'd1;
                    end
                    2'd1: begin
                        mid_q    <= part_data;
                        expected <= 2'd2;
                    end
                    default: begin
                        expected <= 2'd0;
                        elem_idx <= elem_idx + 4'd1;
                    end
                endcase
            end else begin
                // out-of-order slice: throw away the partial word and restart
                seq_err  <= 1'b1;
                expected <= 2'd0;
            end
            if (drop) ovf_err <= 1'b1;
        end
    end

    // FIFO storage, written with the completed word on the high-slice edge
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {part_data, mid_q, low_q};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_assembler.sv
// Testbench for result_assembler: directed scenarios plus randomized frames,
// checked every cycle against a queue-based reference model.
module tb_result_assembler;
    localparam int PART_W = 8;
    localparam int DEPTH  = 4;
    localparam int ELEMS  = 9;

    logic        clk = 1'b0;
    logic        rst, frame_start, part_valid, out_ready;
    logic [1:0]  part_sel;
    logic [7:0]  part_data;
    logic        out_valid, busy, frame_done, seq_err, ovf_err;
    logic [23:0] out_data;
    logic [3:0]  elem_idx;

    always #5 clk = ~clk;

    result_assembler #(.PART_W(PART_W), .FIFO_DEPTH(DEPTH), .ELEMS(ELEMS)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .part_valid(part_valid),
        .part_sel(part_sel), .part_data(part_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .elem_idx(elem_idx),
        .busy(busy), .frame_done(frame_done), .seq_err(seq_err), .ovf_err(ovf_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: phase 0 idle, 1 collecting, 2 draining
    int          m_phase = 0;
    int          m_exp   = 0;
    logic [7:0]  m_lo = '0, m_mid = '0;
    int          m_elem  = 0;
    bit          m_seq = 0, m_ovf = 0;
    logic [23:0] q[$];

    int pops_seen = 0;
    int fd_count  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          pop, complete;
        int          size_before;
        logic [23:0] word;
        complete = 0;
        word = '0;
        if (rst) begin
            m_phase = 0; m_exp = 0; m_elem = 0; m_seq = 0; m_ovf = 0;
            q.delete();
            return;
        end
        size_before = q.size();
        pop = (size_before != 0) && out_ready;
        case (m_phase)
            0: if (frame_start) begin
                m_seq = 0; m_ovf = 0; m_elem = 0; m_exp = 0; m_phase = 1;
            end
            1: if (part_valid) begin
                if (int'(part_sel) == m_exp) begin
                    if (m_exp == 0) begin m_lo = part_data; m_exp = 1; end
                    else if (m_exp == 1) begin m_mid = part_data; m_exp = 2; end
                    else begin
                        word = {part_data, m_mid, m_lo};
                        complete = 1;
                        m_exp = 0;
                        m_elem++;
                        if (m_elem == ELEMS) m_phase = 2;
                    end
                end else begin
                    m_seq = 1;
                    m_exp = 0;
                end
            end
            default: if (size_before == 0) m_phase = 0;
        endcase
        if (pop) void'(q.pop_front());
        if (complete) begin
            if (size_before < DEPTH || pop) q.push_back(word);
            else m_ovf = 1;
        end
    endtask

    // monitor: compare outputs against the model, then advance the model
    always @(negedge clk) begin
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) check("out_data", out_data, q[0]);
        check("elem_idx", elem_idx, m_elem);
        check("busy", busy, m_phase != 0);
        check("frame_done", frame_done, (m_phase == 2) && (q.size() == 0));
        check("seq_err", seq_err, m_seq);
        check("ovf_err", ovf_err, m_ovf);
        if (frame_done) fd_count++;
        if (out_valid && out_ready) pops_seen++;
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic part(input logic [1:0] s, input logic [7:0] d);
        part_valid = 1'b1;
        part_sel   = s;
        part_data  = d;
        tick();
        part_valid = 1'b0;
    endtask

    task automatic triplet(input logic [7:0] k);
        part(2'd0, k);
        part(2'd1, 8'(k + 8'd1));
        part(2'd2, 8'(k + 8'd2));
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) tick();
        check("idle_reached", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; frame_start = 1'b0; part_valid = 1'b0;
        part_sel = 2'd0; part_data = 8'd0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_elem", elem_idx, 0);

        // nominal frame
        pops_seen = 0; fd_count = 0;
        pulse_start();
        for (int e = 0; e < ELEMS; e++) begin
            triplet(8'(3 * e + 1));
            if (e == 0) begin
                check("nom_latency_valid", out_valid, 1);
                check("nom_first_word", out_data, 24'h030201);
            end
        end
        wait_idle(30);
        check("nom_pops", pops_seen, 9);
        check("nom_frame_done", fd_count, 1);
        check("nom_elem", elem_idx, 9);

        // backpressure throughout the frame
        out_ready = 1'b0;
        pulse_start();
        pops_seen = 0; fd_count = 0;
        for (int e = 0; e < ELEMS; e++) triplet(8'(16 * e));
        tick();
        check("bp_ovf", ovf_err, 1);
        check("bp_elem", elem_idx, 9);
        check("bp_busy", busy, 1);
        check("bp_head", out_data, 24'h020100);
        out_ready = 1'b1;
        wait_idle(30);
        check("bp_pops", pops_seen, 4);
        check("bp_frame_done", fd_count, 1);

        // completion on a full FIFO with a pop on the same edge
        out_ready = 1'b0;
        pulse_start();
        check("fp_ovf_cleared", ovf_err, 0);
        pops_seen = 0;
        for (int e = 0; e < 4; e++) triplet(8'(8'h50 + 4 * e));
        part(2'd0, 8'hA0);
        part(2'd1, 8'hA1);
        out_ready = 1'b1;
        part(2'd2, 8'hA2);
        out_ready = 1'b0;
        check("fp_ovf", ovf_err, 0);
        check("fp_one_pop", pops_seen, 1);
        out_ready = 1'b1;
        for (int e = 5; e < ELEMS; e++) triplet(8'(8'h70 + 4 * e));
        wait_idle(30);
        check("fp_all_words", pops_seen, 9);
        check("fp_ovf_end", ovf_err, 0);

        // sequence errors, illegal slice, ignored inputs
        pulse_start();
        part(2'd0, 8'h11);
        part(2'd2, 8'h13);
        check("se_seq", seq_err, 1);
        check("se_elem", elem_idx, 0);
        check("se_no_word", out_valid, 0);
        triplet(8'h40);
        check("se_word", out_data, 24'h424140);
        check("se_elem1", elem_idx, 1);
        part(2'd0, 8'h20);
        part(2'd1, 8'h21);
        part(2'd3, 8'h22);
        check("il_elem", elem_idx, 1);
        pulse_start();
        check("fs_in_collect_busy", busy, 1);
        check("fs_in_collect_seq", seq_err, 1);
        for (int e = 1; e < ELEMS; e++) triplet(8'(8'h80 + 3 * e));
        wait_idle(30);
        triplet(8'hE0);
        tick();
        check("idle_parts_elem", elem_idx, 9);
        check("idle_parts_valid", out_valid, 0);
        check("idle_parts_busy", busy, 0);

        // reset mid-frame with two words buffered
        pulse_start();
        check("start_clears_seq", seq_err, 0);
        for (int e = 0; e < 3; e++) triplet(8'(8'h10 * e));
        out_ready = 1'b0;
        for (int e = 3; e < 5; e++) triplet(8'(8'h10 * e));
        check("rm_buffered", out_valid, 1);
        fd_count = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_valid", out_valid, 0);
        check("rm_busy", busy, 0);
        check("rm_elem", elem_idx, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rm_no_frame_done", fd_count, 0);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            pulse_start();
            for (int c = 0; c < 400 && m_phase != 0; c++) begin
                out_ready   = ($urandom % 3) != 0;
                part_valid  = ($urandom % 4) != 0;
                part_sel    = (($urandom % 12) == 0) ? 2'($urandom % 4) : 2'(m_exp);
                part_data   = 8'($urandom);
                frame_start = ($urandom % 30) == 0;
                rst         = ($urandom % 500) == 0;
                tick();
            end
            part_valid = 1'b0; frame_start = 1'b0; rst = 1'b0; out_ready = 1'b1;
            wait_idle(50);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
